quad_gate_tester: RTL and testbench
===================================

# quad_gate_tester

Sequencer that powers and exercises one quad 2-input gate package (sn7408 pinout: four gates, P14 = VCC, P7 = GND) from a single clock. It applies the 16 standard input vectors gate by gate, waits a settle interval, compares each output pin against the selected gate function, and reports test/error counts and a pass flag. It sits between the bench or board controller and the sn7408 model (or a socketed part), replacing hand-written vector sequences.

## Interface

Parameters:
- `PWR_CYCLES`, 2: cycles between VCC assertion and the first vector (≥1).
- `SETTLE`, 1: cycles each vector is held before its output is sampled (≥1).

Ports. Clock is `clk`; reset is `rst_n`, asynchronous, active-low:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  terminate a run; power removed.
- `mode`  in  3  expected gate function, latched at start.
- `p1 p2 p4 p5 p9 p10 p12 p13`  out  1 each  gate input drives.
- `p14`  out  1  VCC drive.
- `p7`  out  1  GND drive, constant 0.
- `p3 p6 p8 p11`  in  1 each  gate outputs sensed.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  last run had zero errors; held until next start.
- `test_count`  out  5  vectors checked, 0..16.
- `error_count`  out  5  mismatching vectors, 0..16.
- `first_fail`  out  4  index of first mismatching vector; valid only when error_count ≠ 0.

## Operation

- Vector index v = 0..15: gate = v[3:2], A = v[1], B = v[0].
- Gate map: g0 A=P1 B=P2 Y=P3; g1 A=P4 B=P5 Y=P6; g2 A=P9 B=P10 Y=P8; g3 A=P13 B=P12 Y=P11.
- Modes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR. Codes 5–7 are invalid.
- FSM: IDLE → POWER → APPLY → SETTLE → (APPLY | DONE) → IDLE.
  - IDLE: all gate inputs are 0 and p14 is 0. When start=1 and mode is valid, clear counts and latch mode; the next state is POWER.
  - POWER: p14=1. Lasts PWR_CYCLES cycles.
  - APPLY: drive the gate inputs for vector v. Inputs of the other gates keep their last applied values, starting from 0. Lasts 1 cycle.
  - SETTLE: lasts SETTLE cycles.
    - On the last cycle, sample Y of gate v[3:2] and increment test_count.
    - A mismatch against the mode function increments error_count. X or Z counts as a mismatch.
    - On the first mismatch, record first_fail = v.
    - If v = 15, go to DONE; otherwise increment v and go to APPLY.
  - DONE: p14=0, all inputs 0, pass = (error_count == 0), done=1 for one cycle, then IDLE.
- start with an invalid mode: done pulses the next cycle with pass=0 and counts 0. No power is applied.
- start while busy is ignored.
- abort in any non-IDLE state: IDLE next cycle, p14=0, inputs 0, no done pulse. Counts freeze and pass=0.
- abort and start asserted together in IDLE: abort wins and start is ignored.
- Reset, asynchronous at any time including mid-run:
  - all pin drives 0, p14=0;
  - busy, done and pass 0;
  - counts 0, first_fail 0;
  - state IDLE, v=0.
- Counters are 5-bit and saturate-free: the maximum count is 16, so no wrap.

## Timing

- All outputs are registered.
- busy rises on the edge that samples start and falls on the edge that leaves DONE.
- p14 rises 1 cycle after the start edge.
- The first vector is driven PWR_CYCLES cycles after p14 rises.
- Per vector: 1 + SETTLE cycles.
- done pulses exactly 2 + PWR_CYCLES + 16·(1+SETTLE) cycles after the start edge. Defaults: 36.
- Back-to-back runs: start is accepted on the cycle after done.

## Structure

- Shared package `quad_gate_pkg` holds:
  - mode codes (FN_AND … FN_XOR);
  - FSM state encodings;
  - NUM_VECTORS = 16;
  - the pin-map constants.
- Sub-module `gate_ref_model` is combinational: (mode, a, b) → expected Y. It is shared with the verification bench.
- The top-level contains the FSM, the vector counter, the settle/power counter, the pin register bank and the result counters.

## Test plan

- sn7408 attached, mode=0 (AND), start → done at cycle 36, pass=1, test_count=16, error_count=0.
- sn7408 attached, mode=2 (OR) → error_count=8, first_fail=1, pass=0.
- sn7408 attached with P8 forced 0, mode=0 → error_count=1, first_fail=11.
- mode=7, start → done on the next cycle, pass=0, counts 0, p14 never asserted.
- abort at cycle 10 of a run → p14=0 and busy=0 the next cycle, no done. A new start then completes normally with pass=1.
- rst_n low at cycle 20 → all outputs at reset values immediately. start=1 during busy has no effect on the done timing.

Source files
------------

// File: rtl/quad_gate_pkg.sv
// Shared constants for the quad 2-input gate tester: gate function codes,
//   sequencer state encodings, vector count and the sn7408 pin map.
// Latency: n/a (package). Backpressure: n/a.
package quad_gate_pkg;

  // Gate function codes; 5..7 are rejected at start.
  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_NAND = 3'd1;
  localparam logic [2:0] FN_OR   = 3'd2;
  localparam logic [2:0] FN_NOR  = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;

  localparam int unsigned NUM_VECTORS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POWER  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Pin map. The 8-bit drive word holds gate g's A input at bit 2g and its
  // B input at bit 2g+1; the 4-bit sense word holds gate g's Y at bit g.
  localparam int unsigned DRV_P1  = 0;  // g0 A
  localparam int unsigned DRV_P2  = 1;  // g0 B
  localparam int unsigned DRV_P4  = 2;  // g1 A
  localparam int unsigned DRV_P5  = 3;  // g1 B
  localparam int unsigned DRV_P9  = 4;  // g2 A
  localparam int unsigned DRV_P10 = 5;  // g2 B
  localparam int unsigned DRV_P13 = 6;  // g3 A
  localparam int unsigned DRV_P12 = 7;  // g3 B
  localparam int unsigned SNS_P3  = 0;  // g0 Y
  localparam int unsigned SNS_P6  = 1;  // g1 Y
  localparam int unsigned SNS_P8  = 2;  // g2 Y
  localparam int unsigned SNS_P11 = 3;  // g3 Y

  function automatic logic mode_valid(input logic [2:0] m);
    return (m <= FN_XOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Reference gate function: expected Y for a given mode and A/B inputs.
// Latency: combinational. Backpressure: none.
// Ports: i_mode (function code), i_a/i_b (gate inputs), o_y (expected output;
//   0 for invalid codes, which the sequencer never runs).
module gate_ref_model
  import quad_gate_pkg::*;
(
  input  logic [2:0] i_mode,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_y
);

  always_comb begin
    o_y = 1'b0;
    case (i_mode)
      FN_AND:  o_y = i_a & i_b;
      FN_NAND: o_y = ~(i_a & i_b);
      FN_OR:   o_y = i_a | i_b;
      FN_NOR:  o_y = ~(i_a | i_b);
      FN_XOR:  o_y = i_a ^ i_b;
      default: o_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/quad_gate_tester.sv
// Powers a quad 2-input gate package, walks 16 vectors gate by gate, checks
//   each Y against the selected function and reports counts and pass flag.
// Latency: done 2+PWR_CYCLES+16*(1+SETTLE) cycles after start. No backpressure;
//   start is ignored while busy, abort returns to idle next cycle.
// Ports: clk/rst_n; start, abort, mode (control); p1..p13 gate drives, p14 VCC,
//   p7 GND; p3/p6/p8/p11 sensed outputs; busy, done, pass, test_count,
//   error_count, first_fail (status).
module quad_gate_tester
  import quad_gate_pkg::*;
#(
  parameter int PWR_CYCLES = 2,
  parameter int SETTLE     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] mode,
  output logic       p1,
  output logic       p2,
  output logic       p4,
  output logic       p5,
  output logic       p9,
  output logic       p10,
  output logic       p12,
  output logic       p13,
  output logic       p14,
  output logic       p7,
  input  logic       p3,
  input  logic       p6,
  input  logic       p8,
  input  logic       p11,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] test_count,
  output logic [4:0] error_count,
  output logic [3:0] first_fail
);

  localparam int CNT_MAX = (PWR_CYCLES > SETTLE) ? PWR_CYCLES : SETTLE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_vec, w_vec_nxt;
  logic [2:0]       r_mode;
  logic             r_mode_ok;
  logic [7:0]       r_drv, w_drv_nxt;
  logic             r_p14, w_p14_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_chk_vld, r_chk_err;
  logic [3:0]       r_chk_idx;
  logic [4:0]       r_test_cnt, r_err_cnt;
  logic [3:0]       r_first_fail;

  logic [3:0]       w_sns;
  logic             w_exp, w_y, w_mismatch;
  logic             w_accept, w_abort_run, w_sample;

  assign w_sns[SNS_P3]  = p3;
  assign w_sns[SNS_P6]  = p6;
  assign w_sns[SNS_P8]  = p8;
  assign w_sns[SNS_P11] = p11;

  gate_ref_model u_ref (
    .i_mode (r_mode),
    .i_a    (r_vec[1]),
    .i_b    (r_vec[0]),
    .o_y    (w_exp)
  );

  assign w_y         = w_sns[r_vec[3:2]];
  // Case inequality so an undriven or unknown output counts as a failure.
  assign w_mismatch  = (w_y !== w_exp);
  assign w_accept    = (r_state == ST_IDLE) && start && !abort;
  assign w_abort_run = abort && (r_state != ST_IDLE);
  assign w_sample    = (r_state == ST_SETTLE) && (r_cnt == '0) && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_vec_nxt = '0;
          if (mode_valid(mode)) begin
            w_state_nxt = ST_POWER;
            w_cnt_nxt   = CNT_W'(PWR_CYCLES - 1);
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_POWER: begin
        if (r_cnt == '0) w_state_nxt = ST_APPLY;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_APPLY: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = CNT_W'(SETTLE - 1);
      end
      ST_SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_vec == 4'(NUM_VECTORS - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_vec_nxt   = r_vec + 4'd1;
          w_state_nxt = ST_APPLY;
        end
      end
      ST_DONE: begin
        // Hold one extra cycle while the last vector's result is folded in.
        if (!r_chk_vld) begin
          w_state_nxt = ST_IDLE;
          w_vec_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort_run) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_vec_nxt   = '0;
    end
  end

  // Output logic: next values of the registered pin drives and status flags.
  // Drives follow the current state one cycle later, so p14 rises the cycle
  // after start and each vector appears the cycle after its APPLY state.
  always_comb begin
    w_drv_nxt  = r_drv;
    w_p14_nxt  = 1'b0;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    w_pass_nxt = r_pass;
    case (r_state)
      ST_IDLE: begin
        w_drv_nxt = '0;
        if (w_accept) begin
          w_busy_nxt = 1'b1;
          w_pass_nxt = 1'b0;
        end
      end
      ST_POWER:  w_p14_nxt = 1'b1;
      ST_APPLY: begin
        w_p14_nxt = 1'b1;
        w_drv_nxt[{r_vec[3:2], 1'b0}] = r_vec[1];
        w_drv_nxt[{r_vec[3:2], 1'b1}] = r_vec[0];
      end
      ST_SETTLE: w_p14_nxt = 1'b1;
      ST_DONE: begin
        w_drv_nxt = '0;
        if (!r_chk_vld) begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
          w_pass_nxt = r_mode_ok && (r_err_cnt == 5'd0);
        end
      end
      default: w_drv_nxt = '0;
    endcase
    if (w_abort_run) begin
      w_drv_nxt  = '0;
      w_p14_nxt  = 1'b0;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      w_pass_nxt = 1'b0;
    end
  end

  // Pin bank, status flags and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drv        <= '0;
      r_p14        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_mode       <= FN_AND;
      r_mode_ok    <= 1'b0;
      r_chk_vld    <= 1'b0;
      r_chk_err    <= 1'b0;
      r_chk_idx    <= '0;
      r_test_cnt   <= '0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
    end else begin
      r_drv     <= w_drv_nxt;
      r_p14     <= w_p14_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_chk_vld <= w_sample;
      if (w_sample) begin
        r_chk_err <= w_mismatch;
        r_chk_idx <= r_vec;
      end
      if (w_accept) begin
        r_mode       <= mode;
        r_mode_ok    <= mode_valid(mode);
        r_test_cnt   <= '0;
        r_err_cnt    <= '0;
        r_first_fail <= '0;
      end else if (r_chk_vld && !w_abort_run) begin
        r_test_cnt <= r_test_cnt + 5'd1;
        if (r_chk_err) begin
          r_err_cnt <= r_err_cnt + 5'd1;
          if (r_err_cnt == 5'd0) r_first_fail <= r_chk_idx;
        end
      end
    end
  end

  assign p1          = r_drv[DRV_P1];
  assign p2          = r_drv[DRV_P2];
  assign p4          = r_drv[DRV_P4];
  assign p5          = r_drv[DRV_P5];
  assign p9          = r_drv[DRV_P9];
  assign p10         = r_drv[DRV_P10];
  assign p13         = r_drv[DRV_P13];
  assign p12         = r_drv[DRV_P12];
  assign p14         = r_p14;
  assign p7          = 1'b0;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign test_count  = r_test_cnt;
  assign error_count = r_err_cnt;
  assign first_fail  = r_first_fail;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Directed bench for quad_gate_tester with a behavioural sn7408 attached.
module tb_quad_gate_tester;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [2:0] mode;
  logic       p1, p2, p4, p5, p9, p10, p12, p13, p14, p7;
  logic       p3, p6, p8, p11;
  logic       busy, done, pass;
  logic [4:0] test_count, error_count;
  logic [3:0] first_fail;
  logic       force_p8_lo;

  int checks = 0;
  int errors = 0;
  int cyc;
  int dones;

  always #5 clk = ~clk;

  // sn7408: four AND gates; P8 can be stuck low to model a bad gate.
  assign p3  = p1 & p2;
  assign p6  = p4 & p5;
  assign p8  = force_p8_lo ? 1'b0 : (p9 & p10);
  assign p11 = p13 & p12;

  quad_gate_tester dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .p1(p1), .p2(p2), .p4(p4), .p5(p5), .p9(p9), .p10(p10), .p12(p12),
    .p13(p13), .p14(p14), .p7(p7), .p3(p3), .p6(p6), .p8(p8), .p11(p11),
    .busy(busy), .done(done), .pass(pass), .test_count(test_count),
    .error_count(error_count), .first_fail(first_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller sits just after an edge; start is sampled on the next edge.
  task automatic do_start(input logic [2:0] m);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(output int c);
    c = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin
        c = n;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 3'd0; force_p8_lo = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_p14", p14, 0);
    chk("rst_p7", p7, 0);
    chk("rst_drv", {p1, p2, p4, p5, p9, p10, p12, p13}, 0);
    chk("rst_cnts", {test_count, error_count, first_fail}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // AND run with mid-run pin checks
    do_start(3'd0);
    chk("and_busy_rise", busy, 1);
    chk("and_p14_late", p14, 0);
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) chk("and_p14_on", p14, 1);
      if (n == 5) begin
        chk("and_v1_pins", {p1, p2}, 2'b01);
        chk("and_v1_tc", test_count, 1);
      end
      if (n == 29) begin
        chk("and_v13_g3", {p13, p12}, 2'b01);
        chk("and_v13_hold", {p1, p2, p4, p5, p9, p10}, 6'b111111);
      end
      if (done) begin
        cyc = n;
        break;
      end
    end
    chk("and_done_cyc", cyc, 36);
    chk("and_pass", pass, 1);
    chk("and_tc", test_count, 16);
    chk("and_ec", error_count, 0);
    chk("and_busy_fall", busy, 0);
    chk("and_p14_off", p14, 0);
    @(posedge clk); #1;
    chk("and_done_pulse", done, 0);

    // abort and start together in IDLE: abort wins
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abst_busy", busy, 0);
    @(posedge clk); #1;
    chk("abst_p14", p14, 0);

    // OR run with start held high throughout
    mode = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    run_to_done(cyc);
    start = 1'b0;
    chk("or_done_cyc", cyc, 36);
    chk("or_ec", error_count, 8);
    chk("or_ff", first_fail, 1);
    chk("or_pass", pass, 0);
    chk("or_tc", test_count, 16);

    // AND with P8 stuck low
    @(posedge clk); #1;
    force_p8_lo = 1'b1;
    do_start(3'd0);
    run_to_done(cyc);
    force_p8_lo = 1'b0;
    chk("p8_done_cyc", cyc, 36);
    chk("p8_ec", error_count, 1);
    chk("p8_ff", first_fail, 11);
    chk("p8_pass", pass, 0);

    // invalid mode, started on the cycle right after done
    do_start(3'd7);
    chk("inv_busy", busy, 1);
    chk("inv_p14_0", p14, 0);
    @(posedge clk); #1;
    chk("inv_done", done, 1);
    chk("inv_pass", pass, 0);
    chk("inv_cnts", {test_count, error_count}, 0);
    chk("inv_p14_1", p14, 0);
    chk("inv_busy_fall", busy, 0);

    // abort at cycle 10
    @(posedge clk); #1;
    do_start(3'd0);
    repeat (9) @(posedge clk);
    #1;
    chk("ab_p14_pre", p14, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_p14", p14, 0);
    chk("ab_busy", busy, 0);
    chk("ab_drv", {p1, p2, p4, p5, p9, p10, p12, p13}, 0);
    chk("ab_pass", pass, 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ab_no_done", dones, 0);
    chk("ab_tc_frozen", test_count, 3);
    do_start(3'd0);
    run_to_done(cyc);
    chk("ab_rerun_cyc", cyc, 36);
    chk("ab_rerun_pass", pass, 1);

    // asynchronous reset mid-run
    @(posedge clk); #1;
    do_start(3'd2);
    repeat (20) @(posedge clk);
    #1;
    chk("mr_tc", test_count, 8);
    chk("mr_ec", error_count, 4);
    chk("mr_ff", first_fail, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_p14", p14, 0);
    chk("mr_drv", {p1, p2, p4, p5, p9, p10, p12, p13}, 0);
    chk("mr_cnts", {test_count, error_count, first_fail}, 0);
    chk("mr_flags", {done, pass}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(3'd0);
    run_to_done(cyc);
    chk("post_rst_cyc", cyc, 36);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_tc", test_count, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
